perceptron_core: RTL and testbench

//  Parametrised single-neuron perceptron. Signed fixed-point MAC, one input per cycle;
//  run-time selectable activation (Step/Sigmoid/Tanh/ReLU, same order as Common::act_func).

---
 rtl/perceptron_core_if.sv | 34 +++
 rtl/perceptron_core.sv | 208 ++++++++++++++++++++
 tb/tb_perceptron_core.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_core_if.sv
// Host-side bundle for perceptron_core: pass request, weight load/readback
// and result signals. The host drives through 'master', the core through 'slave'.
interface perceptron_core_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 64
);
  localparam int AW = $clog2(N_IN + 1);

  logic                    start;
  logic                    train;
  logic [1:0]              act_sel;
  logic [N_IN*WIDTH-1:0]   x_flat;
  logic [WIDTH-1:0]        target;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [AW-1:0]           rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic [WIDTH-1:0]        y;
  logic                    y_valid;
  logic                    busy;

  modport master (
    output start, train, act_sel, x_flat, target,
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, y, y_valid, busy
  );

  modport slave (
    input  start, train, act_sel, x_flat, target,
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, y, y_valid, busy
  );
endinterface

// File: rtl/perceptron_core.sv
// Single-neuron perceptron: signed fixed-point MAC over one input per cycle,
// selectable hard activation, optional online weight/bias update afterwards.
// Weights and bias live here; the host loads and reads them through the bus.
module perceptron_core #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 64,
  parameter int FRAC  = 32,
  parameter logic signed [WIDTH-1:0] LR_Q = WIDTH'(1) << (FRAC - 3)
) (
  input logic              clk,
  input logic              rst_n,
  perceptron_core_if.slave bus
);

  localparam int AW = $clog2(N_IN + 1);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [AW-1:0] LAST = AW'(N_IN);

  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic signed [WIDTH-1:0] HALF    = ONE >>> 1;
  localparam logic signed [WIDTH-1:0] MAXV    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_UPDATE
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] w      [N_IN];
  logic signed [WIDTH-1:0] x_lat  [N_IN];
  logic signed [WIDTH-1:0] bias;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] delta;
  logic signed [WIDTH-1:0] target_lat;
  logic signed [WIDTH-1:0] y_reg;
  logic signed [WIDTH-1:0] act_val;
  logic signed [WIDTH-1:0] rd_val;
  logic                    y_valid_reg;
  logic                    train_lat;
  logic [1:0]              act_lat;
  logic [AW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    busy;

  // Saturating add: a WIDTH+1 bit sum whose top two bits disagree has overflowed.
  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic signed [WIDTH-1:0] r;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] == s[WIDTH-1]) r = s[WIDTH-1:0];
    else if (s[WIDTH])          r = MINV;
    else                        r = MAXV;
    return r;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic signed [WIDTH-1:0] r;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (s[WIDTH] == s[WIDTH-1]) r = s[WIDTH-1:0];
    else if (s[WIDTH])          r = MINV;
    else                        r = MAXV;
    return r;
  endfunction

  // Fixed-point multiply: full-width product, rescale by FRAC, saturate back to WIDTH.
  function automatic logic signed [WIDTH-1:0] mul(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    logic [WIDTH:0] hi;
    logic signed [WIDTH-1:0] r;
    p  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    p  = p >>> FRAC;
    hi = p[2*WIDTH-1:WIDTH-1];
    if ((&hi) || !(|hi))    r = p[WIDTH-1:0];
    else if (p[2*WIDTH-1])  r = MINV;
    else                    r = MAXV;
    return r;
  endfunction

  // Hard activations; the sigmoid shift cannot overflow because acc>>>2 leaves headroom for ONE/2.
  function automatic logic signed [WIDTH-1:0] act(input logic signed [WIDTH-1:0] a,
                                                  input logic [1:0] sel);
    logic signed [WIDTH-1:0] s;
    logic signed [WIDTH-1:0] r;
    s = (a >>> 2) + HALF;
    r = '0;
    case (sel)
      2'd0: r = a[WIDTH-1] ? '0 : ONE;
      2'd1: begin
        if (s[WIDTH-1])   r = '0;
        else if (s > ONE) r = ONE;
        else              r = s;
      end
      2'd2: begin
        if (a < NEG_ONE)  r = NEG_ONE;
        else if (a > ONE) r = ONE;
        else              r = a;
      end
      default: r = a[WIDTH-1] ? '0 : a;
    endcase
    return r;
  endfunction

  assign idx = cnt[IW-1:0];

  // State register; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state: Compute runs N_IN MAC cycles plus one result cycle, Update N_IN weights plus bias.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (bus.start) state_next = S_COMPUTE;
      S_COMPUTE: if (cnt == LAST) state_next = train_lat ? S_UPDATE : S_IDLE;
      S_UPDATE:  if (cnt == LAST) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers every non-Idle cycle.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Activation of the finished accumulator, used for both y and the training error.
  always_comb begin
    act_val = act(acc, act_lat);
  end

  // Datapath: operand latching, host writes, MAC, result register and weight update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) begin
        w[k]     <= '0;
        x_lat[k] <= '0;
      end
      bias        <= '0;
      acc         <= '0;
      delta       <= '0;
      target_lat  <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      train_lat   <= 1'b0;
      act_lat     <= 2'd0;
      cnt         <= '0;
    end else begin
      y_valid_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < N_IN; k++) x_lat[k] <= bus.x_flat[k*WIDTH +: WIDTH];
            train_lat  <= bus.train;
            act_lat    <= bus.act_sel;
            target_lat <= bus.target;
            acc        <= bias;
            cnt        <= '0;
          end else if (bus.wr_en) begin
            if (bus.wr_addr == LAST)     bias <= bus.wr_data;
            else if (bus.wr_addr < LAST) w[bus.wr_addr[IW-1:0]] <= bus.wr_data;
          end
        end
        S_COMPUTE: begin
          if (cnt != LAST) begin
            acc <= sat_add(acc, mul(w[idx], x_lat[idx]));
            cnt <= cnt + AW'(1);
          end else begin
            y_reg       <= act_val;
            y_valid_reg <= 1'b1;
            delta       <= mul(LR_Q, sat_sub(target_lat, act_val));
            cnt         <= '0;
          end
        end
        S_UPDATE: begin
          if (cnt != LAST) begin
            w[idx] <= sat_add(w[idx], mul(delta, x_lat[idx]));
            cnt    <= cnt + AW'(1);
          end else begin
            bias <= sat_add(bias, delta);
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational readback; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    if (bus.rd_addr == LAST)     rd_val = bias;
    else if (bus.rd_addr < LAST) rd_val = w[bus.rd_addr[IW-1:0]];
  end

  assign bus.rd_data = rd_val;
  assign bus.y       = y_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_perceptron_core.sv
// Bench for perceptron_core: directed passes push expected y into a queue,
// a negedge monitor pops and compares on every y_valid pulse.
module tb_perceptron_core;

  localparam int N_IN  = 4;
  localparam int WIDTH = 64;
  localparam int FRAC  = 32;

  localparam logic signed [63:0] ONE  = 64'sh0000_0001_0000_0000;
  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_EIGHTH  = 64'hFFFF_FFFF_E000_0000;

  typedef logic signed [63:0] vec_t [4];
  typedef logic [63:0] wvec_t [5];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_y;
  vec_t  xs;
  wvec_t ew;
  int found;

  perceptron_core_if #(.N_IN(N_IN), .WIDTH(WIDTH)) bus ();

  perceptron_core #(
    .N_IN (N_IN),
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every y_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.y_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("y_unexpected_pulse", 64'd1, 64'd0);
      end else begin
        exp_y = exp_q.pop_front();
        checkOutput("y", bus.y, exp_y);
      end
    end
  end

  task automatic writeWeight(input int addr, input logic [63:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic checkWeights(input wvec_t e, input string tag);
    for (int a = 0; a < 5; a++) begin
      bus.rd_addr = 3'(a);
      #1;
      checkOutput($sformatf("%s_rd%0d", tag, a), bus.rd_data, e[a]);
    end
  endtask

  // mode 0: plain pass; 1: wr_en together with start; 2: start+wr_en pulsed mid-Compute.
  task automatic applyStimulus(input vec_t xv, input logic [1:0] act, input logic tr,
                               input logic [63:0] tgt, input logic [63:0] expy,
                               input int mode, input int exp_busy, input string tag);
    int lat;
    int busy_n;
    @(negedge clk);
    for (int k = 0; k < 4; k++) bus.x_flat[k*64 +: 64] = xv[k];
    bus.act_sel = act;
    bus.train   = tr;
    bus.target  = tgt;
    bus.start   = 1'b1;
    if (mode == 1) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'd0;
      bus.wr_data = 64'hDEAD;
    end
    exp_q.push_back(expy);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    lat    = -1;
    busy_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.y_valid && lat < 0) lat = n;
      if (bus.busy) busy_n++;
      else break;
      if (mode == 2 && n == 1) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd1;
        bus.wr_data = 64'hBEEF;
      end
      if (mode == 2 && n == 2) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd5);
    checkOutput({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
  endtask

  // Watchdog so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    bus.start = 1'b0; bus.train = 1'b0; bus.act_sel = 2'd0; bus.x_flat = '0;
    bus.target = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    found = 0;

    repeat (2) @(negedge clk);
    checkOutput("reset_y", bus.y, 64'd0);
    checkOutput("reset_y_valid", 64'(bus.y_valid), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    ew = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    checkWeights(ew, "reset");
    rst_n = 1'b1;

    // Test 1: zero weights, ReLU
    xs = '{ONE, 2*ONE, 3*ONE, 4*ONE};
    applyStimulus(xs, 2'd3, 1'b0, 64'd0, 64'd0, 0, 5, "t1");
    checkWeights(ew, "t1");

    // Test 2: acc = -0.5 under each activation; also an out-of-range write
    for (int k = 0; k < 4; k++) writeWeight(k, ONE);
    writeWeight(4, 64'hFFFF_FFFD_8000_0000);
    writeWeight(5, 64'h1234_5678);
    ew = '{ONE, ONE, ONE, ONE, 64'hFFFF_FFFD_8000_0000};
    checkWeights(ew, "t2");
    bus.rd_addr = 3'd5; #1;
    checkOutput("t2_rd_oor5", bus.rd_data, 64'd0);
    bus.rd_addr = 3'd7; #1;
    checkOutput("t2_rd_oor7", bus.rd_data, 64'd0);
    xs = '{ONE, 64'sd0, ONE, 64'sd0};
    applyStimulus(xs, 2'd0, 1'b0, 64'd0, 64'd0, 0, 5, "t2_step");
    applyStimulus(xs, 2'd1, 1'b0, 64'd0, 64'h0000_0000_6000_0000, 0, 5, "t2_sigmoid");
    applyStimulus(xs, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 5, "t2_tanh");
    applyStimulus(xs, 2'd3, 1'b0, 64'd0, 64'd0, 0, 5, "t2_relu");

    // Test 3: one training pass from zero weights
    for (int k = 0; k < 5; k++) writeWeight(k, 64'd0);
    xs = '{ONE, ONE, 64'sd0, 64'sd0};
    applyStimulus(xs, 2'd0, 1'b1, 64'd0, ONE, 0, 10, "t3_train");
    ew = '{NEG_EIGHTH, NEG_EIGHTH, 64'd0, 64'd0, NEG_EIGHTH};
    checkWeights(ew, "t3");
    applyStimulus(xs, 2'd0, 1'b0, 64'd0, 64'd0, 0, 5, "t3_rerun");

    // Test 4: add and multiply saturation
    writeWeight(0, 64'h4000_0000_0000_0000);
    writeWeight(1, 64'h4000_0000_0000_0000);
    writeWeight(2, 64'd0);
    writeWeight(3, 64'd0);
    writeWeight(4, 64'd0);
    xs = '{ONE, ONE, 64'sd0, 64'sd0};
    applyStimulus(xs, 2'd3, 1'b0, 64'd0, MAXV, 0, 5, "t4_addsat");
    xs = '{4*ONE, 64'sd0, 64'sd0, 64'sd0};
    applyStimulus(xs, 2'd3, 1'b0, 64'd0, MAXV, 0, 5, "t4_mulsat_pos");
    xs = '{-4*ONE, 64'sd0, 64'sd0, 64'sd0};
    applyStimulus(xs, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_0000_0000, 0, 5, "t4_mulsat_neg");

    // Test 5: ignored start/wr_en, then reset in the middle of Update
    for (int k = 0; k < 4; k++) writeWeight(k, ONE);
    writeWeight(4, 64'd0);
    xs = '{ONE, ONE, ONE, ONE};
    applyStimulus(xs, 2'd3, 1'b0, 64'd0, 4*ONE, 1, 5, "t5_wr_with_start");
    applyStimulus(xs, 2'd3, 1'b0, 64'd0, 4*ONE, 2, 5, "t5_mid_compute");
    repeat (6) @(negedge clk);
    ew = '{ONE, ONE, ONE, ONE, 64'd0};
    checkWeights(ew, "t5");

    @(negedge clk);
    for (int k = 0; k < 4; k++) bus.x_flat[k*64 +: 64] = xs[k];
    bus.act_sel = 2'd3; bus.train = 1'b1; bus.target = '0; bus.start = 1'b1;
    exp_q.push_back(4*ONE);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.y_valid) begin
        found = 1;
        break;
      end
    end
    checkOutput("t5_train_y_valid_seen", 64'(found), 64'd1);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("t5_rst_y", bus.y, 64'd0);
    checkOutput("t5_rst_y_valid", 64'(bus.y_valid), 64'd0);
    ew = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    checkWeights(ew, "t5_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset: zero weights, sigmoid gives one half
    applyStimulus(xs, 2'd1, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 0, 5, "post_rst");

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
